irq_aggregator: RTL
===================

# irq_aggregator

Avalon-MM interrupt aggregator that sits directly downstream of the interval timer and the other peripheral IRQ sources. It collects up to 16 interrupt lines, captures each as level or rising edge, applies a mask and raises one registered `irq_out` to the CPU. Software reads the pending and active sources, the lowest-numbered active source ID, and a saturating count of `irq_out` assertions over a 16-bit slave port with the same timing as the timer's `s1` port.

## Interface
- `N_SRC`, default 8: number of interrupt inputs, legal range 1..16.
- `SYNC`, default 0: 0 gives a 1-flop input register (same-clock sources); 1 gives a 2-flop synchronizer (asynchronous sources).
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low; clock `clk`.
- `chipselect`  in  1  slave select.
- `address`  in  3  register word address.
- `write_n`  in  1  active-low write strobe; a write happens when `chipselect && !write_n`.
- `writedata`  in  16  write data.
- `readdata`  out  16  registered read data.
- `irq_in`  in  N_SRC  interrupt sources; bit 0 is the timer `irq`.
- `irq_out`  out  1  aggregated interrupt to the CPU, registered.

## Operation
- Input stage: `irq_in` goes through the `SYNC`-selected register chain; its output is `in_q`. `prev_q` is `in_q` delayed by one cycle.
- Pending bit i, source in level mode (`EDGE[i]=0`): each cycle it loads `in_q[i]`. Software clear and force writes have no effect on it.
- Pending bit i, source in edge mode (`EDGE[i]=1`):
  - Sets on `in_q[i] & ~prev_q[i]`, or on a FORCE write with bit i = 1.
  - Clears on a PENDING write with bit i = 1.
  - If set and clear occur in the same cycle, set wins.
- Active vector = pending & MASK. Each cycle `irq_out` loads (active != 0).
- Register map, 16-bit words; bits at index N_SRC and above read 0 and ignore writes:
  - 0 STATUS, RO: active vector.
  - 1 PENDING, R / write-1-to-clear: raw pending vector.
  - 2 MASK, RW: 1 = enabled.
  - 3 EDGE, RW: 1 = edge mode, 0 = level mode.
  - 4 ID, RO: bit 15 = any active; [3:0] = lowest index of an active source; reads 0x0000 when nothing is active.
  - 5 FORCE, WO: write 1 to set pending on edge-mode sources; reads 0.
  - 6 COUNT, RW: counts 0->1 transitions of `irq_out`; saturates at 0xFFFF; any write clears it; reads the count.
  - 7: reserved; reads 0, writes ignored.
- Reads have no side effects.
- Changing EDGE on a source clears that source's pending bit in the same write cycle.

## Timing
- Reset values: `readdata`=0, `irq_out`=0, all pending bits 0, MASK=0, EDGE=0, COUNT=0, input flops 0.
- Read latency 1: `readdata` is registered every cycle from the mux on `address`, independent of `chipselect`. No wait states.
- Writes take effect at the clock edge where the strobe is sampled and are visible to a read issued on the next cycle.
- Input to `irq_out` latency (MASK bit set):
  - `SYNC=0`: `irq_in` rises before edge k; pending is set at edge k+1; `irq_out` = 1 after edge k+2.
  - `SYNC=1`: one cycle more.
- Clearing the last active source (PENDING W1C, or MASK write to 0) at edge k drops `irq_out` after edge k+1.
- An edge-mode input that stays high does not re-pend after a clear. It needs a new low-to-high transition.
- A pulse shorter than one cycle is not guaranteed to be captured. With `SYNC=0` it must be held across one rising clock edge.
- COUNT: if an increment and a write hit the same edge, the write wins and the result is 0. At 0xFFFF further increments are dropped.
- ID priority is fixed: lowest index wins. ID is computed combinationally from the registered active vector before the read mux.
- Asserting reset mid-operation clears everything asynchronously. `irq_out` drops immediately. Edges present at reset release are not captured until `prev_q` has been loaded, one cycle after release.

## Test plan
- Reset: after release, read addresses 0–7 -> all return 0x0000; `irq_out`=0.
- Level path, `SYNC=0`: MASK=0x0001, hold `irq_in[0]`=1 -> `irq_out`=1 at the 3rd edge; STATUS=0x0001; ID=0x8000. Drop the input -> `irq_out`=0 three cycles later. Write PENDING=0x0001 while the input is held high -> pending stays 1.
- Edge path with priority: EDGE=0x00C0, MASK=0x00C0, pulse `irq_in[6]` and `irq_in[7]` for one cycle -> PENDING=0x00C0, ID=0x8006. Write PENDING=0x0040 -> ID=0x8007. Write PENDING=0x0080 -> `irq_out` falls one cycle after the write.
- Set beats clear: on `irq_in[6]`, make a rising edge reach the pending logic in the same cycle as a PENDING=0x0040 write -> PENDING=0x0040 afterwards.
- FORCE and COUNT: on an edge-mode source, write FORCE=0x0040 then clear it, five times -> COUNT=5. Preload the count to 0xFFFF by repeated cycling -> COUNT stays 0xFFFF. Write COUNT -> 0.
- `SYNC=1` on an asynchronous source: drive `irq_in[3]` in level mode from a clock at 0.37x `clk` -> `irq_out` follows with a 4-cycle latency and never glitches within a cycle; masked bits (MASK=0) never reach `irq_out`.

Source files
------------

// File: rtl/irq_aggregator.sv
// Interrupt aggregator: captures up to 16 level/edge sources, masks them and
// drives a single registered irq_out, with a small Avalon-MM register file.
module irq_aggregator #(
    parameter int N_SRC = 8,
    parameter int SYNC  = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic [2:0]        address,
    input  logic              write_n,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    input  logic [N_SRC-1:0]  irq_in,
    output logic              irq_out
);

    localparam logic [2:0] A_STATUS  = 3'd0;
    localparam logic [2:0] A_PENDING = 3'd1;
    localparam logic [2:0] A_MASK    = 3'd2;
    localparam logic [2:0] A_EDGE    = 3'd3;
    localparam logic [2:0] A_ID      = 3'd4;
    localparam logic [2:0] A_FORCE   = 3'd5;
    localparam logic [2:0] A_COUNT   = 3'd6;

    logic             wr_en;
    logic [N_SRC-1:0] wdata;
    logic             unused_wdata;
    logic [N_SRC-1:0] in_q, prev_q, pend_q, pend_nxt;
    logic [N_SRC-1:0] mask_q, edge_q, active;
    logic [N_SRC-1:0] rise, force_set, pend_clr, edge_chg;
    logic [15:0]      count_q, count_nxt, rd_mux, id_word;
    logic [3:0]       id_idx;
    logic             irq_nxt;

    assign wr_en        = chipselect && !write_n;
    assign wdata        = writedata[N_SRC-1:0];
    assign unused_wdata = ^writedata;

    function automatic logic [15:0] zext(input logic [N_SRC-1:0] v);
        logic [15:0] r;
        r = '0;
        r[N_SRC-1:0] = v;
        return r;
    endfunction

    // Input capture: single register or two-flop synchronizer
    if (SYNC != 0) begin : g_sync
        logic [N_SRC-1:0] meta_q;
        // Two-stage synchronizer for sources in another clock domain
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                meta_q <= '0;
                in_q   <= '0;
            end else begin
                meta_q <= irq_in;
                in_q   <= meta_q;
            end
        end
    end else begin : g_nosync
        // Single input register for same-clock sources
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) in_q <= '0;
            else          in_q <= irq_in;
        end
    end

    // Delayed copy of the captured inputs for rising-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_q <= '0;
        else          prev_q <= in_q;
    end

    assign rise      = in_q & ~prev_q;
    assign force_set = (wr_en && address == A_FORCE)   ? wdata : '0;
    assign pend_clr  = (wr_en && address == A_PENDING) ? wdata : '0;
    assign edge_chg  = (wr_en && address == A_EDGE)    ? (wdata ^ edge_q) : '0;

    // Per-source pending update; a mode change discards stale pending state
    always_comb begin
        pend_nxt = pend_q;
        for (int i = 0; i < N_SRC; i++) begin
            if (edge_chg[i])                   pend_nxt[i] = 1'b0;
            else if (!edge_q[i])               pend_nxt[i] = in_q[i];
            else if (rise[i] || force_set[i])  pend_nxt[i] = 1'b1;
            else if (pend_clr[i])              pend_nxt[i] = 1'b0;
        end
    end

    assign active  = pend_q & mask_q;
    assign irq_nxt = |active;

    // Lowest-index active source wins
    always_comb begin
        id_idx = 4'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) id_idx = 4'(i);
        end
        id_word = irq_nxt ? {1'b1, 11'd0, id_idx} : 16'h0000;
    end

    // Saturating count of irq_out rising transitions; a write always clears
    always_comb begin
        count_nxt = count_q;
        if (wr_en && address == A_COUNT)
            count_nxt = 16'h0000;
        else if (irq_nxt && !irq_out && count_q != 16'hFFFF)
            count_nxt = count_q + 16'd1;
    end

    // Read mux, registered below regardless of chipselect
    always_comb begin
        rd_mux = 16'h0000;
        case (address)
            A_STATUS:  rd_mux = zext(active);
            A_PENDING: rd_mux = zext(pend_q);
            A_MASK:    rd_mux = zext(mask_q);
            A_EDGE:    rd_mux = zext(edge_q);
            A_ID:      rd_mux = id_word;
            A_COUNT:   rd_mux = count_q;
            default:   rd_mux = 16'h0000;
        endcase
    end

    // Pending, configuration, counter and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q   <= '0;
            mask_q   <= '0;
            edge_q   <= '0;
            count_q  <= '0;
            irq_out  <= 1'b0;
            readdata <= '0;
        end else begin
            pend_q   <= pend_nxt;
            count_q  <= count_nxt;
            irq_out  <= irq_nxt;
            readdata <= rd_mux;
            if (wr_en && address == A_MASK) mask_q <= wdata;
            if (wr_en && address == A_EDGE) edge_q <= wdata;
        end
    end

endmodule
